// File: rtl/instr_encoder.sv
// Packs symbolic instructions into 9-bit machine words and writes them to instruction memory from address 0,
// terminating each program with the all-ones Ack word. Define ENC_STRICT_EN to reject nonzero excess operand bits.
module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              InValid,
    output logic              InReady,
    input  logic [3:0]        InClass,
    input  logic [5:0]        InOpnd,
    output logic              WrEn,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [8:0]        WrData,
    output logic              Done,
    output logic              Error,
    output logic [ADDR_W:0]   WordCount
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FINISH,
        DONE,
        ERR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [8:0]        wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic [8:0] enc_word;
    logic       enc_illegal;
    logic       enc_is_end;
    logic       strict_bad;
    logic       overflow;
    logic       reject;

    always_comb begin
        enc_word    = '0;
        enc_illegal = 1'b0;
        enc_is_end  = 1'b0;
        case (InClass)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6:
                enc_word = {InClass[2:0], InOpnd};
            4'd7: enc_word = {5'b11100, InOpnd[3:0]};
            4'd8: enc_word = {5'b11101, InOpnd[3:0]};
            4'd9: begin
                enc_word    = {4'b1111, InOpnd[4:0]};
                enc_illegal = &InOpnd[4:0];
            end
            4'd10: begin
                enc_word   = 9'h1FF;
                enc_is_end = 1'b1;
            end
            default: enc_illegal = 1'b1;
        endcase
    end

`ifdef ENC_STRICT_EN
    always_comb begin
        strict_bad = 1'b0;
        case (InClass)
            4'd7, 4'd8: strict_bad = |InOpnd[5:4];
            4'd9:       strict_bad = InOpnd[5];
            4'd10:      strict_bad = |InOpnd;
            default:    strict_bad = 1'b0;
        endcase
    end
`else
    assign strict_bad = 1'b0;
`endif

    // The last slot is reserved for Ack, so only END may land there.
    assign overflow = !enc_is_end && (addr_q == LAST_ADDR);
    assign reject   = enc_illegal || strict_bad || overflow;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = done_q;
        error_d   = error_q;
        count_d   = count_q;
        if (Start) begin
            state_d = LOAD;
            addr_d  = '0;
            done_d  = 1'b0;
            error_d = 1'b0;
            count_d = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (InValid) begin
                        if (reject) begin
                            state_d = ERR;
                            error_d = 1'b1;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = enc_word;
                            count_d   = count_q + (ADDR_W+1)'(1);
                            if (enc_is_end) begin
                                state_d = FINISH;
                            end else begin
                                addr_d = addr_q + ADDR_W'(1);
                            end
                        end
                    end
                end
                FINISH: begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            error_q   <= error_d;
            count_q   <= count_d;
        end
    end

    // A write already registered when Reset arrives is suppressed rather than allowed to reach memory.
    assign WrEn      = wr_en_q && !Reset;
    assign InReady   = (state_q == LOAD) && !Start;
    assign WrAddr    = wr_addr_q;
    assign WrData    = wr_data_q;
    assign Done      = done_q;
    assign Error     = error_q;
    assign WordCount = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Drives two instr_encoder instances (ADDR_W=10 and ADDR_W=2) with shared stimulus and compares
// every output each cycle against a transaction-level reference model.
module tb_instr_encoder;

`ifdef ENC_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset, Start, InValid;
    logic [3:0] InClass;
    logic [5:0] InOpnd;

    logic       InReady0, WrEn0, Done0, Error0;
    logic [9:0] WrAddr0;
    logic [8:0] WrData0;
    logic [10:0] WordCount0;

    logic       InReady1, WrEn1, Done1, Error1;
    logic [1:0] WrAddr1;
    logic [8:0] WrData1;
    logic [2:0] WordCount1;

    int testsRun = 0;
    int testsFailed = 0;

    int m_depth [2] = '{1024, 4};
    bit m_loading [2];
    bit m_finishing [2];
    int m_addr [2];
    bit m_wr [2];
    int m_wdata [2];
    int m_waddr [2];
    bit m_done [2];
    bit m_err [2];
    int m_count [2];

    always #5 Clk = ~Clk;

    instr_encoder u_big (
        .Clk(Clk), .Reset(Reset), .Start(Start), .InValid(InValid), .InReady(InReady0),
        .InClass(InClass), .InOpnd(InOpnd), .WrEn(WrEn0), .WrAddr(WrAddr0), .WrData(WrData0),
        .Done(Done0), .Error(Error0), .WordCount(WordCount0)
    );

    instr_encoder #(.ADDR_W(2)) u_small (
        .Clk(Clk), .Reset(Reset), .Start(Start), .InValid(InValid), .InReady(InReady1),
        .InClass(InClass), .InOpnd(InOpnd), .WrEn(WrEn1), .WrAddr(WrAddr1), .WrData(WrData1),
        .Done(Done1), .Error(Error1), .WordCount(WordCount1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
        end
    endtask

    // Word layout from the opcode table: 64 operand values per 3-bit class, then the 111xx sub-spaces.
    function automatic void refEncode(input int cls, input int opnd, input int addr, input int depth,
                                      output bit err, output int word, output bit isEnd);
        err = 1'b0;
        word = 0;
        isEnd = (cls == 10);
        if (cls <= 6) begin
            word = cls * 64 + opnd;
        end else if (cls == 7) begin
            word = 448 + opnd % 16;
            if (STRICT && opnd >= 16) err = 1'b1;
        end else if (cls == 8) begin
            word = 464 + opnd % 16;
            if (STRICT && opnd >= 16) err = 1'b1;
        end else if (cls == 9) begin
            word = 480 + opnd % 32;
            if (opnd % 32 == 31) err = 1'b1;
            if (STRICT && opnd >= 32) err = 1'b1;
        end else if (cls == 10) begin
            word = 511;
            if (STRICT && opnd != 0) err = 1'b1;
        end else begin
            err = 1'b1;
        end
        if (!isEnd && addr == depth - 1) err = 1'b1;
    endfunction

    task automatic checkInstance(input int k, input bit rst, input bit start);
        logic ready, wen, done, err;
        logic [31:0] data, waddr, cnt;
        string nm;
        nm = (k == 0) ? "big" : "small";
        if (k == 0) begin
            ready = InReady0; wen = WrEn0; done = Done0; err = Error0;
            data = 32'(WrData0); waddr = 32'(WrAddr0); cnt = 32'(WordCount0);
        end else begin
            ready = InReady1; wen = WrEn1; done = Done1; err = Error1;
            data = 32'(WrData1); waddr = 32'(WrAddr1); cnt = 32'(WordCount1);
        end
        checkOutput({nm, ".InReady"}, 32'(ready), 32'(m_loading[k] && !start));
        checkOutput({nm, ".WrEn"}, 32'(wen), 32'(m_wr[k] && !rst));
        if (m_wr[k] && !rst) begin
            checkOutput({nm, ".WrData"}, data, m_wdata[k]);
            checkOutput({nm, ".WrAddr"}, waddr, m_waddr[k]);
        end
        checkOutput({nm, ".Done"}, 32'(done), 32'(m_done[k]));
        checkOutput({nm, ".Error"}, 32'(err), 32'(m_err[k]));
        checkOutput({nm, ".WordCount"}, cnt, m_count[k]);
    endtask

    task automatic advanceModel(input int k, input bit rst, input bit start, input bit valid,
                                input int cls, input int opnd);
        bit e, isEnd;
        int w;
        m_wr[k] = 1'b0;
        if (rst) begin
            m_loading[k] = 0; m_finishing[k] = 0; m_addr[k] = 0;
            m_done[k] = 0; m_err[k] = 0; m_count[k] = 0;
        end else if (start) begin
            m_loading[k] = 1; m_finishing[k] = 0; m_addr[k] = 0;
            m_done[k] = 0; m_err[k] = 0; m_count[k] = 0;
        end else if (m_finishing[k]) begin
            m_finishing[k] = 0;
            m_done[k] = 1;
        end else if (m_loading[k] && valid) begin
            refEncode(cls, opnd, m_addr[k], m_depth[k], e, w, isEnd);
            if (e) begin
                m_loading[k] = 0;
                m_err[k] = 1;
            end else begin
                m_wr[k] = 1;
                m_wdata[k] = w;
                m_waddr[k] = m_addr[k];
                m_count[k]++;
                if (isEnd) begin
                    m_loading[k] = 0;
                    m_finishing[k] = 1;
                end else begin
                    m_addr[k]++;
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit start, input bit valid, input int cls, input int opnd);
        Reset = rst;
        Start = start;
        InValid = valid;
        InClass = 4'(cls);
        InOpnd = 6'(opnd);
        #1;
        for (int k = 0; k < 2; k++) begin
            checkInstance(k, rst, start);
            advanceModel(k, rst, start, valid, cls, opnd);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input int cls, input int opnd);
        applyStimulus(1'b0, 1'b0, 1'b1, cls, opnd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic startProgram();
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);
    endtask

    initial begin
        bit rst, start, valid;
        int r, cls, opnd;

        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
        idle(2);

        startProgram();
        issue(0, 5); issue(1, 9); issue(3, 2); issue(10, 0);
        idle(3);

        startProgram();
        issue(7, 3); issue(8, 12); issue(9, 7); issue(6, 63); issue(10, 0);
        idle(3);

        startProgram();
        issue(9, 31);
        idle(2);
        startProgram();
        idle(1);

        startProgram();
        issue(0, 1); issue(0, 2); issue(0, 3); issue(0, 4);
        idle(2);
        startProgram();
        issue(0, 1); issue(0, 2); issue(0, 3); issue(10, 0);
        idle(3);

        startProgram();
        issue(7, 19);
        idle(2);

        startProgram();
        issue(0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
        idle(2);

        startProgram();
        issue(0, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 0, 2);
        issue(0, 3); issue(12, 0); issue(10, 0);
        idle(2);

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 24) == 0);
            valid = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 99);
            if (r < 85) cls = $urandom_range(0, 9);
            else if (r < 95) cls = 10;
            else cls = $urandom_range(11, 15);
            opnd = (cls == 10 && $urandom_range(0, 3) != 0) ? 0 : $urandom_range(0, 63);
            applyStimulus(rst, start, valid, cls, opnd);
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program-load encoder that produces the 9-bit machine words the control decoder consumes. It accepts symbolic instructions (operation class plus operand) over a valid/ready handshake, packs each into the 9-bit format, and writes the words sequentially into instruction memory starting at address 0. It terminates every program with the all-ones Ack word. It sits between the testbench/host loader and the instruction memory write port, ahead of fetch.

## Interface
- ADDR_W, 10, instruction memory address width; capacity DEPTH = 2**ADDR_W words
- Clk  input  1  clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  single-cycle pulse; begins a new program at address 0
- InValid  input  1  symbolic instruction present on InClass/InOpnd
- InReady  output  1  encoder can accept this cycle
- InClass  input  4  operation class (see Operation)
- InOpnd  input  6  operand/immediate field
- WrEn  output  1  instruction memory write strobe
- WrAddr  output  ADDR_W  write address
- WrData  output  9  encoded machine word
- Done  output  1  program complete, Ack word written
- Error  output  1  load aborted (illegal class, collision or overflow)
- WordCount  output  ADDR_W+1  words written in current program, including Ack

## Operation
- Encoding by InClass:
  - 0 LOAD: {000, InOpnd[5:0]}
  - 1 STR: {001, InOpnd[5:0]}
  - 2-5 ALU: {InClass[2:0], InOpnd[5:0]}, giving opcodes 010-101
  - 6 BRANCH: {110, InOpnd[5:0]}
  - 7 MOVETO: {11100, InOpnd[3:0]}
  - 8 MOVEFROM: {11101, InOpnd[3:0]}
  - 9 IMDLUT: {1111, InOpnd[4:0]}; InOpnd[4:0] = 11111 is an Ack collision and raises Error
  - 10 END: emits 9'h1FF
  - 11-15: illegal, raise Error
- FSM states and transitions:
  - IDLE: Start -> LOAD
  - LOAD: accepts instructions; accepted END -> FINISH; error condition -> ERR
  - FINISH: writes the Ack word, then -> DONE
  - DONE: holds
  - ERR: holds
- From DONE or ERR, Start -> LOAD, clearing Done, Error, WordCount and the address to 0.
- InReady = (state == LOAD) && !Start.
- Address counter: increments after each write and never wraps.
  - A non-END instruction accepted while the address equals DEPTH-1 raises Error (overflow); the last slot is reserved for Ack.
  - END accepted at address DEPTH-1 is legal; WordCount reaches DEPTH.
- An erroring instruction is not written, and the address does not advance.
- Start during LOAD restarts immediately at address 0. An InValid in the same cycle is not accepted.

## Timing
- Reset values: all outputs 0, state IDLE, address 0.
- Accept happens on the cycle where InValid && InReady.
- The write is registered: WrEn=1 with WrData/WrAddr on the following cycle, for exactly 1 cycle.
- Throughput: one word per cycle during LOAD.
- END timing, with END accepted at cycle t:
  - t+1: WrEn with 9'h1FF; state FINISH; InReady=0
  - t+2: Done=1
- Error timing: Error=1 the cycle after the offending accept. No WrEn that cycle. InReady=0 from then on.
- WordCount updates in the same cycle as its WrEn.
- Reset mid-program returns to IDLE in one cycle. No further writes; a pending registered write is cancelled.

## Configuration
- ENC_STRICT_EN defined:
  - Operand bits beyond the class's field width must be zero; otherwise Error.
  - Examples: InOpnd[5:4] for MOVETO/MOVEFROM, InOpnd[5] for IMDLUT, any nonzero InOpnd for END.
- Undefined: excess operand bits are silently truncated. Illegal classes and the IMDLUT Ack collision still raise Error.

## Test plan
- Reset, Start, then LOAD 5, STR 9, ALU class 3 opnd 2, END:
  - Writes 0x005, 0x049, 0x0C2, 0x1FF at addresses 0-3 on consecutive cycles.
  - Done=1 two cycles after END accept; WordCount=4.
- MOVETO 3, MOVEFROM 12, IMDLUT 7, BRANCH 63: WrData 0x1C3, 0x1DC, 0x1E7, 0x1BF.
- IMDLUT opnd 31: no write, Error=1 next cycle, InReady=0. A following Start restarts at address 0 with Error cleared.
- ADDR_W=2, three LOADs then a fourth LOAD: Error, address stays 3. Repeat with END as the fourth: Ack at address 3, Done=1, WordCount=4.
- With ENC_STRICT_EN, MOVETO opnd 0x13 raises Error. Without it, the same input writes 0x1C3.
- Reset asserted the cycle after an accept: no WrEn, all outputs 0, InReady=0 until Start.
